mic1_exec_ctrl: RTL
===================

// Module: mic1_exec_ctrl
// PURPOSE
//  Execution sequencer for the MIC-1 datapath. It takes single-cycle run/step/halt
//  command pulses from the front-panel button FSM and generates the subcycle phase
//  enables that advance the datapath one microinstruction (PHASES subcycles) at a time.
//  It supports free-run, single-step, breakpoint on MPC, microcode halt and memory-wait
//  stall. It drives the run/idle status LEDs and a microinstruction counter.
// PARAMETERS
//  PHASES    4    subcycles per microinstruction (>=2)
//  MPC_W     9    width of MPC / breakpoint address
//  DIV_W     16   width of the rate prescaler
//  RATE_DIV  1    clocks per phase_en in RUN/STEP/DRAIN (1..2**DIV_W-1)
//  CNT_W     16   width of uinstr_count
// PORTS
//  clk             in   1       system clock (6 MHz)
//  reset           in   1       asynchronous, active-high reset
//  cmd_run         in   1       1-clk pulse: start free-run
//  cmd_step        in   1       1-clk pulse: execute one microinstruction
//  cmd_halt        in   1       1-clk pulse: stop at next microinstruction boundary
//  mem_wait        in   1       datapath memory busy; stalls the last phase
//  dp_halt         in   1       microcode halt request (sampled at completion)
//  mpc             in   MPC_W   address of the microinstruction in execution
//  bp_en           in   1       breakpoint enable
//  bp_addr         in   MPC_W   breakpoint MPC
//  phase_en        out  1       1-clk pulse: datapath executes subcycle phase_idx
//  phase_idx       out  2       current subcycle, 0..PHASES-1 ($clog2(PHASES) bits)
//  uinstr_done     out  1       1-clk pulse coincident with phase_en of the last phase
//  uinstr_count    out  CNT_W   completed microinstructions, wraps at 2**CNT_W
//  led_run_status  out  1       high in RUN
//  led_idle        out  1       high in IDLE
//  bp_hit          out  1       sticky: stopped by breakpoint
//  halted          out  1       sticky: stopped by dp_halt
// BEHAVIOUR
//  Reset: state=IDLE, phase_idx=0, prescaler=0, uinstr_count=0. phase_en, uinstr_done,
//   led_run_status, bp_hit and halted are 0. led_idle=1. All outputs are registered.
//  States: IDLE, RUN, STEP, DRAIN.
//   IDLE : cmd_halt has priority over cmd_step, which has priority over cmd_run.
//          cmd_step -> STEP; cmd_run -> RUN; cmd_halt -> no effect.
//          Entering RUN or STEP clears bp_hit and halted.
//   RUN  : cmd_halt or cmd_step -> DRAIN. cmd_run is ignored.
//   STEP : all commands ignored; -> IDLE on completion.
//   DRAIN: all commands ignored; -> IDLE on completion.
//  Prescaler: counts 0..RATE_DIV-1 while not IDLE; held at 0 in IDLE.
//   A tick occurs when it holds RATE_DIV-1 (RATE_DIV=1: every clk).
//   The first phase_en comes RATE_DIV clks after the state leaves IDLE.
//  phase_en = tick & !(mem_wait & phase_idx==PHASES-1).
//   A stalled tick is lost; the prescaler keeps running. At most one phase_en per tick.
//   phase_idx increments after each phase_en and wraps PHASES-1 -> 0.
//  Completion = phase_en with phase_idx==PHASES-1. uinstr_done pulses in the same cycle.
//   uinstr_count increments in the next cycle.
//  Stop at completion while in RUN (checked in this order):
//   1. dp_halt=1 -> IDLE, halted<=1.
//   2. bp_en=1 and mpc==bp_addr -> IDLE, bp_hit<=1.
//   3. cmd_halt or cmd_step in the completion cycle -> IDLE directly (no DRAIN).
//   Otherwise RUN continues.
//  In STEP/DRAIN, dp_halt and the breakpoint still set their flags at completion.
//  Stopping always leaves phase_idx=0. A microinstruction is never abandoned mid-phase.
//  mem_wait held forever keeps RUN/STEP/DRAIN pending. Only reset recovers.
//  Async reset mid-microinstruction returns everything to reset values immediately.
//   No phase_en is issued during or on the edge of release.
//  Command pulses wider than 1 clk are acted on once per state entry (level effects
//   are ignored in the states that ignore commands).
// TESTING (RATE_DIV=2, PHASES=4)
//  1. Reset, then cmd_step -> 4 phase_en pulses 2 clks apart with phase_idx 0,1,2,3.
//     uinstr_done with idx 3; uinstr_count=1; led_idle=1 after.
//  2. cmd_run, let 3 uinstrs complete, then cmd_halt during phase 1 -> the current
//     uinstr finishes; count=4, led_run_status=0, phase_idx=0.
//  3. bp_en=1, bp_addr=0x05; run with mpc=0x05 in the 2nd uinstr -> IDLE after the
//     2nd uinstr_done, bp_hit=1. The next cmd_run clears bp_hit.
//  4. mem_wait=1 at phase_idx=3 for 10 clks -> no phase_en while asserted;
//     phase 3 fires on the first tick after release.
//  5. dp_halt=1 and breakpoint match at the same completion -> halted=1, bp_hit=0.
//     Simultaneous cmd_run+cmd_step in IDLE -> STEP.
//  6. Assert reset during phase 2 of RUN -> all outputs are at reset values within
//     the same cycle; no phase_en for RATE_DIV clks after release and a new cmd.

Source files
------------

// File: rtl/mic1_exec_ctrl.sv
// Execution sequencer for the MIC-1 datapath.
// Turns run/step/halt command pulses into per-subcycle phase enables. Supports
// free-run, single-step, MPC breakpoint, microcode halt and memory-wait stalls.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_run/cmd_step/cmd_halt  1-clk command pulses from the front panel
//   mem_wait                   stalls the last phase while the memory is busy
//   dp_halt                    microcode halt request, sampled at completion
//   mpc, bp_en, bp_addr        breakpoint compare inputs
//   phase_en, phase_idx        subcycle enable pulse and its index
//   uinstr_done                pulses with the phase_en of the last phase
//   uinstr_count               completed microinstructions (wrapping)
//   led_run_status, led_idle   status LEDs
//   bp_hit, halted             sticky stop-cause flags
module mic1_exec_ctrl #(
    parameter int unsigned PHASES   = 4,
    parameter int unsigned MPC_W    = 9,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned RATE_DIV = 1,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned IDX_W   = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_halt,
    input  logic             mem_wait,
    input  logic             dp_halt,
    input  logic [MPC_W-1:0] mpc,
    input  logic             bp_en,
    input  logic [MPC_W-1:0] bp_addr,
    output logic             phase_en,
    output logic [IDX_W-1:0] phase_idx,
    output logic             uinstr_done,
    output logic [CNT_W-1:0] uinstr_count,
    output logic             led_run_status,
    output logic             led_idle,
    output logic             bp_hit,
    output logic             halted
);

    localparam logic [DIV_W-1:0] PSC_LAST = DIV_W'(RATE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PHASES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] psc;
    logic [DIV_W-1:0] psc_nx;
    logic [IDX_W-1:0] idx_nx;
    logic             phase_en_nx;
    logic             done_nx;
    logic [CNT_W-1:0] count_nx;
    logic             bp_hit_nx;
    logic             halted_nx;
    logic             tick;
    logic             bp_match;
    logic             stop_req;

    // State, prescaler and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            psc            <= '0;
            phase_idx      <= '0;
            phase_en       <= 1'b0;
            uinstr_done    <= 1'b0;
            uinstr_count   <= '0;
            led_run_status <= 1'b0;
            led_idle       <= 1'b1;
            bp_hit         <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= state_nx;
            psc            <= psc_nx;
            phase_idx      <= idx_nx;
            phase_en       <= phase_en_nx;
            uinstr_done    <= done_nx;
            uinstr_count   <= count_nx;
            led_run_status <= (state_nx == S_RUN);
            led_idle       <= (state_nx == S_IDLE);
            bp_hit         <= bp_hit_nx;
            halted         <= halted_nx;
        end
    end

    // Next-state, flag and phase sequencing logic.
    // uinstr_done (registered) marks the completion cycle, so stop decisions are
    // taken at the edge that closes the last phase.
    always_comb begin
        state_nx    = state;
        bp_hit_nx   = bp_hit;
        halted_nx   = halted;
        psc_nx      = '0;
        idx_nx      = phase_idx;
        phase_en_nx = 1'b0;
        done_nx     = 1'b0;
        count_nx    = uinstr_count;

        bp_match = bp_en && (mpc == bp_addr);
        stop_req = cmd_halt || cmd_step;
        tick     = (state != S_IDLE) && (psc == PSC_LAST);

        // Stop-cause flags: microcode halt outranks the breakpoint
        if ((state != S_IDLE) && uinstr_done) begin
            if (dp_halt) begin
                halted_nx = 1'b1;
            end else if (bp_match) begin
                bp_hit_nx = 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (cmd_halt) begin
                    state_nx = S_IDLE;
                end else if (cmd_step) begin
                    state_nx  = S_STEP;
                    bp_hit_nx = 1'b0;
                    halted_nx = 1'b0;
                end else if (cmd_run) begin
                    state_nx  = S_RUN;
                    bp_hit_nx = 1'b0;
                    halted_nx = 1'b0;
                end
            end
            S_RUN: begin
                if (uinstr_done) begin
                    if (dp_halt || bp_match || stop_req) begin
                        state_nx = S_IDLE;
                    end
                end else if (stop_req) begin
                    state_nx = S_DRAIN;
                end
            end
            S_STEP, S_DRAIN: begin
                if (uinstr_done) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Prescaler restarts on entry and is parked at zero in IDLE
        if ((state != S_IDLE) && (state_nx != S_IDLE) && !tick) begin
            psc_nx = psc + DIV_W'(1);
        end

        if (phase_en) begin
            idx_nx = (phase_idx == IDX_LAST) ? '0 : phase_idx + IDX_W'(1);
        end

        // A tick on a stalled last phase is dropped; the prescaler keeps going
        phase_en_nx = tick && (state_nx != S_IDLE) &&
                      !(mem_wait && (idx_nx == IDX_LAST));
        done_nx     = phase_en_nx && (idx_nx == IDX_LAST);

        if (uinstr_done) begin
            count_nx = uinstr_count + CNT_W'(1);
        end
    end

endmodule
